// File: rtl/prog_divider_pkg.sv
// prog_divider_pkg: shared mode encodings and divisor limits for the programmable divider
package prog_divider_pkg;
  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;
  localparam int   MIN_DIV     = 2;
endpackage

// File: rtl/divider_out_decode.sv
// divider_out_decode: next OUT from next COUNT/DIV/MODE so OUT stays aligned with COUNT
module divider_out_decode
  import prog_divider_pkg::*;
#(
  parameter int M = 8
) (
  input  logic [M-1:0] count,
  input  logic [M-1:0] div,
  input  logic         mode,
  output logic         out
);
  assign out = (mode == MODE_SQUARE) ? (count >= (div >> 1)) : (count == div - M'(1));
endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable divide-by-N with pulse/square output and TC strobe
// DIVIDER_IMMEDIATE_LOAD_EN: apply a valid divisor on the next edge instead of at wrap
module prog_clock_divider
  import prog_divider_pkg::*;
#(
  parameter int M           = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic         mode,
  input  logic [M-1:0] div_in,
  input  logic         div_load,
  output logic         div_busy,
  output logic         div_ack,
  output logic         div_err,
  output logic [M-1:0] count,
  output logic         out,
  output logic         tc
);
  logic [M-1:0] div, count_n, div_n;
  logic         good, wrap, apply, tc_n, out_n;
  assign good = div_load && div_in >= M'(MIN_DIV);
  assign wrap = enable && count == div - M'(1);
`ifdef DIVIDER_IMMEDIATE_LOAD_EN
  assign apply    = good;
  assign div_n    = apply ? div_in : div;
  assign tc_n     = wrap && !apply;
  assign div_busy = 1'b0;
`else
  logic [M-1:0] shadow;
  logic         pending;
  // a disabled counter has no wrap to wait for, so a pending load applies at once
  assign apply    = pending && (wrap || !enable);
  assign div_n    = apply ? shadow : div;
  assign tc_n     = wrap;
  assign div_busy = pending;
  always_ff @(posedge clock) begin
    if (clear) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (good) shadow <= div_in;
      pending <= good || (pending && !apply);
    end
  end
`endif
  assign count_n = (apply || wrap) ? '0 : enable ? count + M'(1) : count;
  divider_out_decode #(.M(M)) u_decode (
    .count(count_n),
    .div  (div_n),
    .mode (mode),
    .out  (out_n)
  );
  always_ff @(posedge clock) begin
    if (clear) begin
      count   <= '0;
      div     <= M'(DEFAULT_DIV);
      out     <= 1'b0;
      tc      <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      count   <= count_n;
      div     <= div_n;
      out     <= (enable || apply) ? out_n : out;
      tc      <= tc_n;
      div_ack <= apply;
      div_err <= div_load && !good;
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: scoreboard bench; a cycle model queues expected outputs per edge
module tb_prog_clock_divider;
  localparam int M = 8;
  logic         clock = 1'b0, clear = 1'b1, enable = 1'b0, mode = 1'b0, div_load = 1'b0;
  logic [M-1:0] div_in = '0;
  logic         div_busy, div_ack, div_err, out, tc;
  logic [M-1:0] count;
  typedef struct packed {
    logic [7:0] count;
    logic       out, tc, busy, ack, err;
  } exp_t;
  exp_t       sb[$];
  int         n_cmp = 0, n_bad = 0, tc_seen = 0;
  logic [7:0] m_count = 8'd0, m_div = 8'd5, m_shadow = 8'd0;
  logic       m_pend = 1'b0, m_out = 1'b0;
  prog_clock_divider #(.M(M), .DEFAULT_DIV(5)) dut (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode),
    .div_in(div_in), .div_load(div_load), .div_busy(div_busy),
    .div_ack(div_ack), .div_err(div_err), .count(count), .out(out), .tc(tc)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic c, input logic e, input logic md, input logic [7:0] din, input logic ld);
    exp_t       x;
    logic [7:0] nc;
    logic       ok;
    @(negedge clock);
    clear = c; enable = e; mode = md; div_in = din; div_load = ld;
    x  = '0;
    ok = ld && din >= 8'd2;
    if (c) begin
      m_count = 8'd0; m_div = 8'd5; m_shadow = 8'd0; m_pend = 1'b0; m_out = 1'b0;
    end else begin
      x.err = ld && !ok;
      x.tc  = e && (m_count == m_div - 8'd1);
      nc    = !e ? m_count : x.tc ? 8'd0 : m_count + 8'd1;
`ifdef DIVIDER_IMMEDIATE_LOAD_EN
      if (ok) begin m_div = din; nc = 8'd0; x.ack = 1'b1; x.tc = 1'b0; end
`else
      if (m_pend && (x.tc || !e)) begin m_div = m_shadow; nc = 8'd0; x.ack = 1'b1; m_pend = 1'b0; end
      if (ok) begin m_shadow = din; m_pend = 1'b1; end
`endif
      if (e || x.ack) m_out = md ? (nc >= m_div / 8'd2) : (nc == m_div - 8'd1);
      m_count = nc;
    end
    x.count = m_count; x.out = m_out; x.busy = m_pend;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    chk("count", 32'(count), 32'(x.count));
    chk("out", 32'(out), 32'(x.out));
    chk("tc", 32'(tc), 32'(x.tc));
    chk("div_busy", 32'(div_busy), 32'(x.busy));
    chk("div_ack", 32'(div_ack), 32'(x.ack));
    chk("div_err", 32'(div_err), 32'(x.err));
    if (tc) tc_seen++;
  endtask
  task automatic run(input int n, input logic md);
    repeat (n) step(1'b0, 1'b1, md, 8'd0, 1'b0);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    run(12, 1'b0);
    tc_seen = 0; run(10, 1'b0); chk("tc_per_10_div5", tc_seen, 2);
    run(10, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd4, 1'b1);
    run(15, 1'b1);
    tc_seen = 0; run(12, 1'b1); chk("tc_per_12_div4", tc_seen, 3);
    step(1'b0, 1'b1, 1'b0, 8'd5, 1'b1);
    run(10, 1'b0);
    repeat (8) if (m_count != 8'd1) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd3, 1'b1);
    run(12, 1'b0);
    tc_seen = 0; run(9, 1'b0); chk("tc_per_9_div3", tc_seen, 3);
    step(1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    tc_seen = 0; run(9, 1'b0); chk("tc_after_err", tc_seen, 3);
    repeat (8) if (m_count != 8'd2) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd6, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    run(12, 1'b0);
    repeat (10) if (m_count != 8'd0) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd4, 1'b1);
    repeat (10) if (m_count != 8'd3) step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    tc_seen = 0; run(10, 1'b0); chk("tc_per_10_after_clear", tc_seen, 2);
    step(1'b0, 1'b1, 1'b1, 8'd2, 1'b1);
    run(6, 1'b1);
    tc_seen = 0; run(10, 1'b1); chk("tc_per_10_div2", tc_seen, 5);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 5) != 0),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 1'($urandom_range(0, 7) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
